// File: rtl/snake_body_engine_if.sv
// ---------------------------------------------------------------------------
// snake_body_engine_if
// Bundles the step handshake (go/dir/grow -> busy/done/status) and the
// single-port segment RAM bus used by snake_body_engine.
//   master : game FSM + RAM side (drives go, dir, grow, ram_q)
//   slave  : the body engine (drives RAM controls and status)
// Signals:
//   go, dir[1:0], grow            step request and its qualifiers
//   ram_q[XW+YW+1:0]              RAM read data (1-cycle latency)
//   ram_wren, ram_address, ram_data  RAM write/read controls
//   busy, done, length, head_x, head_y, collide  status
// ---------------------------------------------------------------------------
interface snake_body_engine_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int AW = 11
) ();
  logic              go;
  logic [1:0]        dir;
  logic              grow;
  logic [XW+YW+1:0]  ram_q;
  logic              ram_wren;
  logic [AW-1:0]     ram_address;
  logic [XW+YW+1:0]  ram_data;
  logic              busy;
  logic              done;
  logic [AW:0]       length;
  logic [XW-1:0]     head_x;
  logic [YW-1:0]     head_y;
  logic              collide;

  modport master (
    output go, dir, grow, ram_q,
    input  ram_wren, ram_address, ram_data, busy, done, length, head_x, head_y, collide
  );

  modport slave (
    input  go, dir, grow, ram_q,
    output ram_wren, ram_address, ram_data, busy, done, length, head_x, head_y, collide
  );
endinterface

// File: rtl/snake_body_engine.sv
// ---------------------------------------------------------------------------
// snake_body_engine
// Owns a single-port segment RAM (address 0 = head, one {type,x,y} word per
// segment). After reset it writes the default snake; on each accepted step it
// writes the new head, shifts every segment one slot toward the tail, and can
// append one segment. Grid edges wrap.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (aborts any step, reruns INIT)
//   bus      snake_body_engine_if.slave: step handshake, RAM bus, status
// Optional feature macro: SNAKE_SELF_COLLIDE_EN
//   defined   -> collide flags a new head landing on a remaining body segment
//   undefined -> collide is constant 0, no comparator is built
// All outputs are registered; each state's outputs are loaded on the edge
// that enters the state, so ram_* always describe the current state.
// ---------------------------------------------------------------------------
module snake_body_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int AW       = 11,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 6,
  parameter int START_X  = 20,
  parameter int START_Y  = 10,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  snake_body_engine_if.slave bus
);

  localparam int DW = XW + YW + 2;

  localparam logic [1:0]    TYPE_HEAD  = 2'b01;
  localparam logic [1:0]    TYPE_BODY  = 2'b00;
  localparam logic [AW:0]   INIT_LEN_C = (AW+1)'(INIT_LEN);
  localparam logic [AW:0]   MAX_LEN_C  = (AW+1)'(MAX_LEN);
  localparam logic [AW:0]   ONE_C      = (AW+1)'(1);
  localparam logic [XW-1:0] START_X_C  = XW'(START_X);
  localparam logic [YW-1:0] START_Y_C  = YW'(START_Y);
  localparam logic [XW-1:0] X_MAX_C    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX_C    = YW'(GRID_H - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_RD0, S_LAT0, S_HEAD, S_RD, S_LAT, S_WR, S_APPEND, S_DONE
  } state_t;

  state_t          state_r;
  logic [AW:0]     idx_r;
  logic [AW:0]     length_r;
  logic [1:0]      dir_r;
  logic            grow_r;
  logic [XW-1:0]   prev_x_r;
  logic [YW-1:0]   prev_y_r;
  logic [XW-1:0]   curr_x_r;
  logic [YW-1:0]   curr_y_r;
  logic [XW-1:0]   head_x_r;
  logic [YW-1:0]   head_y_r;
  logic            ram_wren_r;
  logic [AW-1:0]   ram_address_r;
  logic [DW-1:0]   ram_data_r;
  logic            busy_r;
  logic            done_r;

  logic [XW-1:0]   new_x_s;
  logic [YW-1:0]   new_y_s;
  logic [XW-1:0]   q_x_s;
  logic [YW-1:0]   q_y_s;
  logic [YW-1:0]   init_y_s;
  logic [1:0]      init_type_s;
  logic [AW:0]     idx_next_s;
  logic            grow_ok_s;
  logic            last_s;

  // x after one move: only left/right change x; the grid edges wrap
  function automatic logic [XW-1:0] next_x(input logic [XW-1:0] x, input logic [1:0] d);
    logic [XW-1:0] r;
    case (d)
      2'b10:   r = (x == {XW{1'b0}}) ? X_MAX_C : x - XW'(1);
      2'b11:   r = (x == X_MAX_C) ? {XW{1'b0}} : x + XW'(1);
      default: r = x;
    endcase
    return r;
  endfunction

  // y after one move: only up/down change y; the grid edges wrap
  function automatic logic [YW-1:0] next_y(input logic [YW-1:0] y, input logic [1:0] d);
    logic [YW-1:0] r;
    case (d)
      2'b00:   r = (y == {YW{1'b0}}) ? Y_MAX_C : y - YW'(1);
      2'b01:   r = (y == Y_MAX_C) ? {YW{1'b0}} : y + YW'(1);
      default: r = y;
    endcase
    return r;
  endfunction

  // Next-head arithmetic, RAM word split, and loop bookkeeping
  always_comb begin
    new_x_s     = next_x(head_x_r, dir_r);
    new_y_s     = next_y(head_y_r, dir_r);
    q_x_s       = bus.ram_q[XW+YW-1:YW];
    q_y_s       = bus.ram_q[YW-1:0];
    init_y_s    = START_Y_C + YW'(idx_r);
    idx_next_s  = idx_r + ONE_C;
    // A grow request at MAX_LEN is dropped here, so the tail simply moves.
    grow_ok_s   = grow_r && (length_r < MAX_LEN_C);
    last_s      = (idx_r == (length_r - ONE_C));
    if (idx_r == {(AW+1){1'b0}}) begin
      init_type_s = TYPE_HEAD;
    end else begin
      init_type_s = TYPE_BODY;
    end
  end

`ifdef SNAKE_SELF_COLLIDE_EN
  logic collide_r;
  logic hit_s;

  // In LAT, head_x_r/head_y_r already hold the new head. The old tail moves
  // away this step (so it cannot be hit) unless the snake grows.
  always_comb begin
    if ((q_x_s == head_x_r) && (q_y_s == head_y_r) && (!last_s || grow_ok_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end
`endif

  // Main FSM: INIT fill, step sequencing, registered RAM controls and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_INIT;
      idx_r         <= {(AW+1){1'b0}};
      length_r      <= INIT_LEN_C;
      dir_r         <= 2'b00;
      grow_r        <= 1'b0;
      prev_x_r      <= {XW{1'b0}};
      prev_y_r      <= {YW{1'b0}};
      curr_x_r      <= {XW{1'b0}};
      curr_y_r      <= {YW{1'b0}};
      head_x_r      <= START_X_C;
      head_y_r      <= START_Y_C;
      ram_wren_r    <= 1'b0;
      ram_address_r <= {AW{1'b0}};
      ram_data_r    <= {DW{1'b0}};
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
`ifdef SNAKE_SELF_COLLIDE_EN
      collide_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_INIT: begin
          // idx runs one past the last segment so the final write gets its
          // own cycle before the RAM bus is released.
          if (idx_r == INIT_LEN_C) begin
            state_r    <= S_IDLE;
            ram_wren_r <= 1'b0;
            busy_r     <= 1'b0;
            idx_r      <= {(AW+1){1'b0}};
          end else begin
            ram_wren_r    <= 1'b1;
            ram_address_r <= idx_r[AW-1:0];
            ram_data_r    <= {init_type_s, START_X_C, init_y_s};
            idx_r         <= idx_next_s;
          end
        end
        S_IDLE: begin
          if (bus.go) begin
            state_r       <= S_RD0;
            dir_r         <= bus.dir;
            grow_r        <= bus.grow;
            ram_wren_r    <= 1'b0;
            ram_address_r <= {AW{1'b0}};
            busy_r        <= 1'b1;
`ifdef SNAKE_SELF_COLLIDE_EN
            collide_r     <= 1'b0;
`endif
          end else begin
            ram_wren_r <= 1'b0;
          end
        end
        S_RD0: begin
          state_r <= S_LAT0;
        end
        S_LAT0: begin
          prev_x_r      <= q_x_s;
          prev_y_r      <= q_y_s;
          state_r       <= S_HEAD;
          ram_wren_r    <= 1'b1;
          ram_address_r <= {AW{1'b0}};
          ram_data_r    <= {TYPE_HEAD, new_x_s, new_y_s};
          head_x_r      <= new_x_s;
          head_y_r      <= new_y_s;
          idx_r         <= ONE_C;
        end
        S_HEAD: begin
          state_r       <= S_RD;
          ram_wren_r    <= 1'b0;
          ram_address_r <= idx_r[AW-1:0];
        end
        S_RD: begin
          state_r <= S_LAT;
        end
        S_LAT: begin
          curr_x_r   <= q_x_s;
          curr_y_r   <= q_y_s;
`ifdef SNAKE_SELF_COLLIDE_EN
          if (hit_s) begin
            collide_r <= 1'b1;
          end
`endif
          state_r    <= S_WR;
          ram_wren_r <= 1'b1;
          ram_data_r <= {TYPE_BODY, prev_x_r, prev_y_r};
        end
        S_WR: begin
          prev_x_r <= curr_x_r;
          prev_y_r <= curr_y_r;
          idx_r    <= idx_next_s;
          if (last_s) begin
            if (grow_ok_s) begin
              // The displaced old tail becomes the new last segment.
              state_r       <= S_APPEND;
              ram_wren_r    <= 1'b1;
              ram_address_r <= length_r[AW-1:0];
              ram_data_r    <= {TYPE_BODY, curr_x_r, curr_y_r};
            end else begin
              state_r    <= S_DONE;
              ram_wren_r <= 1'b0;
            end
          end else begin
            state_r       <= S_RD;
            ram_wren_r    <= 1'b0;
            ram_address_r <= idx_next_s[AW-1:0];
          end
        end
        S_APPEND: begin
          length_r   <= length_r + ONE_C;
          state_r    <= S_DONE;
          ram_wren_r <= 1'b0;
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= S_INIT;
          idx_r      <= {(AW+1){1'b0}};
          ram_wren_r <= 1'b0;
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ram_wren    = ram_wren_r;
  assign bus.ram_address = ram_address_r;
  assign bus.ram_data    = ram_data_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.length      = length_r;
  assign bus.head_x      = head_x_r;
  assign bus.head_y      = head_y_r;
`ifdef SNAKE_SELF_COLLIDE_EN
  assign bus.collide     = collide_r;
`else
  assign bus.collide     = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_engine.sv
// ---------------------------------------------------------------------------
// tb_snake_body_engine
// Self-checking bench for snake_body_engine with a behavioural segment RAM.
// A queue model of the snake predicts every RAM write of INIT and of each
// step; the writes are pushed to a scoreboard when a step is requested and
// popped as the DUT issues them. A table of steps checks latency, head and
// length; hand-written sequences cover wrap, grow at MAX_LEN, go while busy,
// reset mid-step and self-collision.
// ---------------------------------------------------------------------------
module tb_snake_body_engine;
  localparam int XW = 8, YW = 7, AW = 11;
  localparam int MAX_LEN = 10, INIT_LEN = 6;
  localparam int START_X = 20, START_Y = 10, GRID_W = 160, GRID_H = 120;
  localparam int DW = XW + YW + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  snake_body_engine_if #(.XW(XW), .YW(YW), .AW(AW)) bus ();

  snake_body_engine #(
    .XW(XW), .YW(YW), .AW(AW), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
    .START_X(START_X), .START_Y(START_Y), .GRID_W(GRID_W), .GRID_H(GRID_H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Behavioural single-port RAM, read data one cycle after the address
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  typedef struct packed { logic [XW-1:0] x; logic [YW-1:0] y; } pt_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [1:0] dir; logic grow; int lat; int hx; int hy; int len; } vec_t;

  pt_t  body[$];
  wr_t  exp_q[$];
  logic exp_collide;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic wr_t mk_wr(input int a, input logic [1:0] t, input pt_t p);
    wr_t w;
    w.a = AW'(a);
    w.d = {t, p.x, p.y};
    return w;
  endfunction

  task automatic model_reset();
    pt_t p;
    body.delete();
    exp_q.delete();
    exp_collide = 1'b0;
    for (int i = 0; i < INIT_LEN; i++) begin
      p.x = XW'(START_X);
      p.y = YW'(START_Y + i);
      body.push_back(p);
      exp_q.push_back(mk_wr(i, (i == 0) ? 2'b01 : 2'b00, p));
    end
  endtask

  task automatic model_step(input logic [1:0] d, input logic g);
    int   nx, ny, len;
    logic gok, hit;
    pt_t  nh;
    nx = int'(body[0].x);
    ny = int'(body[0].y);
    case (d)
      2'b00:   ny = (ny == 0) ? GRID_H - 1 : ny - 1;
      2'b01:   ny = (ny == GRID_H - 1) ? 0 : ny + 1;
      2'b10:   nx = (nx == 0) ? GRID_W - 1 : nx - 1;
      default: nx = (nx == GRID_W - 1) ? 0 : nx + 1;
    endcase
    nh.x = XW'(nx);
    nh.y = YW'(ny);
    len  = body.size();
    gok  = g && (len < MAX_LEN);
    exp_q.push_back(mk_wr(0, 2'b01, nh));
    for (int i = 1; i < len; i++) exp_q.push_back(mk_wr(i, 2'b00, body[i-1]));
    if (gok) exp_q.push_back(mk_wr(len, 2'b00, body[len-1]));
    hit = 1'b0;
    for (int i = 1; i < len; i++)
      if ((i < len - 1 || gok) && body[i] == nh) hit = 1'b1;
    body.push_front(nh);
    if (!gok) void'(body.pop_back());
`ifdef SNAKE_SELF_COLLIDE_EN
    exp_collide = hit;
`else
    exp_collide = 1'b0;
`endif
  endtask

  task automatic check_write();
    wr_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write",
               bus.ram_address, bus.ram_data);
    end else begin
      e = exp_q.pop_front();
      check("ram_write", {bus.ram_address, bus.ram_data}, {e.a, e.d});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wren"}, bus.ram_wren, 1'b0);
    check({tag, "_addr"}, bus.ram_address, 0);
    check({tag, "_data"}, bus.ram_data, 0);
    check({tag, "_busy"}, bus.busy, 1'b1);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_length"}, bus.length, INIT_LEN);
    check({tag, "_head_x"}, bus.head_x, START_X);
    check({tag, "_head_y"}, bus.head_y, START_Y);
    check({tag, "_collide"}, bus.collide, 1'b0);
  endtask

  // Reset has just been released: expect the INIT writes, then idle.
  task automatic run_init();
    int writes = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.ram_wren) begin
        writes++;
        check_write();
      end
      if (!bus.busy) break;
    end
    check("init_writes", writes, INIT_LEN);
    check("init_busy", bus.busy, 1'b0);
    check("init_length", bus.length, INIT_LEN);
    check("init_pending", exp_q.size(), 0);
  endtask

  // One step; lat = cycles from the go sample edge to done (-1 on timeout).
  // extra_go > 0 pulses go again that many cycles into the step.
  task automatic do_step(input logic [1:0] d, input logic g, input int extra_go, output int lat);
    model_step(d, g);
    @(negedge clk);
    bus.go   = 1'b1;
    bus.dir  = d;
    bus.grow = g;
    @(posedge clk); #1;
    bus.go = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      bus.go = (c == extra_go);
      if (bus.ram_wren) check_write();
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    bus.go = 1'b0;
    check("step_busy_at_done", bus.busy, 1'b0);
    check("step_pending", exp_q.size(), 0);
    check("step_length", bus.length, body.size());
    check("step_head_x", bus.head_x, body[0].x);
    check("step_head_y", bus.head_y, body[0].y);
    check("step_collide", bus.collide, exp_collide);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  vec_t vecs[7];
  int   lat;
  int   extra_cnt;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // From the reset snake; collide expectation in row 5 comes from the model.
    vecs[0] = '{2'b11, 1'b0, 19, 21, 10, 6};
    vecs[1] = '{2'b00, 1'b1, 20, 21,  9, 7};
    vecs[2] = '{2'b10, 1'b0, 22, 20,  9, 7};
    vecs[3] = '{2'b00, 1'b1, 23, 20,  8, 8};
    vecs[4] = '{2'b11, 1'b0, 25, 21,  8, 8};
    vecs[5] = '{2'b01, 1'b0, 25, 21,  9, 8};
    vecs[6] = '{2'b11, 1'b0, 25, 22,  9, 8};

    bus.go = 1'b0; bus.dir = 2'b00; bus.grow = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_init();

    for (int i = 0; i < 7; i++) begin
      do_step(vecs[i].dir, vecs[i].grow, 0, lat);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_head_x", bus.head_x, vecs[i].hx);
      check("vec_head_y", bus.head_y, vecs[i].hy);
      check("vec_length", bus.length, vecs[i].len);
    end

    // Right-edge wrap
    for (int k = 0; k < 200 && body[0].x != XW'(GRID_W - 1); k++) do_step(2'b11, 1'b0, 0, lat);
    check("pre_wrap_x", bus.head_x, GRID_W - 1);
    do_step(2'b11, 1'b0, 0, lat);
    check("wrap_right_x", bus.head_x, 0);

    // Top-edge wrap
    for (int k = 0; k < 200 && body[0].y != YW'(0); k++) do_step(2'b00, 1'b0, 0, lat);
    check("pre_wrap_y", bus.head_y, 0);
    do_step(2'b00, 1'b0, 0, lat);
    check("wrap_up_y", bus.head_y, GRID_H - 1);

    // Grow up to MAX_LEN; the third grow is dropped
    do_step(2'b10, 1'b1, 0, lat);
    check("grow9_latency", lat, 26);
    check("grow9_length", bus.length, 9);
    do_step(2'b10, 1'b1, 0, lat);
    check("grow10_latency", lat, 29);
    check("grow10_length", bus.length, 10);
    do_step(2'b10, 1'b1, 0, lat);
    check("grow_at_max_latency", lat, 31);
    check("grow_at_max_length", bus.length, 10);

    // go while busy is ignored: one done, no follow-on step
    do_step(2'b10, 1'b0, 5, lat);
    check("busy_go_latency", lat, 31);
    extra_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) extra_cnt++;
    end
    check("busy_go_ignored", extra_cnt, 0);

    // Reset in the middle of the shift loop
    @(negedge clk);
    bus.go = 1'b1; bus.dir = 2'b10; bus.grow = 1'b0;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midstep_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_init();

    // Self-collision from the reset snake, then cleared by the next go
    do_step(2'b01, 1'b0, 0, lat);
    check("collide_latency", lat, 19);
    check("collide_head_y", bus.head_y, 11);
`ifdef SNAKE_SELF_COLLIDE_EN
    check("collide_set", bus.collide, 1'b1);
`else
    check("collide_off", bus.collide, 1'b0);
`endif
    do_step(2'b10, 1'b0, 0, lat);
    check("collide_clear", bus.collide, 1'b0);
    check("collide_clear_head_x", bus.head_x, 19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
